// File: rtl/convb_param_loader_if.sv
// Word stream from the RISC-V side into the convb parameter loader.
interface convb_param_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/convb_param_loader.sv
// Streams weights, then biases, into the per-unit memories of a convb block
// and raises conv_ready once every unit has been fully loaded.
module convb_param_loader #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BITS      = 17,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 88,
  parameter int NUMBER_OF_UNITS   = 11,
  parameter int WEIGHTS_PER_UNIT  = KERNAL_SIZE*KERNAL_SIZE*3*NUMBER_OF_FILTERS/NUMBER_OF_UNITS,
  parameter int BIAS_PER_UNIT     = NUMBER_OF_FILTERS/NUMBER_OF_UNITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  convb_param_loader_if.slave        stream,
  output logic [DATA_WIDTH-1:0]      riscv_data,
  output logic [ADDRESS_BITS-1:0]    riscv_address,
  output logic [NUMBER_OF_UNITS-1:0] wm_enable_write,
  output logic [NUMBER_OF_UNITS-1:0] bm_enable_write,
  output logic                       busy,
  output logic                       load_done,
  output logic                       conv_ready
);

  localparam int MAX_WORDS = (WEIGHTS_PER_UNIT > BIAS_PER_UNIT) ? WEIGHTS_PER_UNIT : BIAS_PER_UNIT;
  localparam int WORD_W    = $clog2(MAX_WORDS + 1);
  localparam int UNIT_W    = $clog2(NUMBER_OF_UNITS + 1);

  typedef enum logic [1:0] {IDLE, WEIGHTS, BIAS, DONE} state_t;

  state_t              state;
  logic [WORD_W-1:0]   word_cnt;
  logic [UNIT_W-1:0]   unit_cnt;
  logic [WORD_W-1:0]   last_word;
  logic                accept;

  always_comb begin
    busy      = (state == WEIGHTS) || (state == BIAS);
    accept    = busy && stream.s_valid;
    last_word = (state == BIAS) ? WORD_W'(BIAS_PER_UNIT - 1) : WORD_W'(WEIGHTS_PER_UNIT - 1);
  end

  assign stream.s_ready = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      word_cnt        <= '0;
      unit_cnt        <= '0;
      riscv_data      <= '0;
      riscv_address   <= '0;
      wm_enable_write <= '0;
      bm_enable_write <= '0;
      load_done       <= 1'b0;
      conv_ready      <= 1'b0;
    end else begin
      wm_enable_write <= '0;
      bm_enable_write <= '0;
      load_done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state      <= WEIGHTS;
            word_cnt   <= '0;
            unit_cnt   <= '0;
            conv_ready <= 1'b0;
          end
        end
        WEIGHTS, BIAS: begin
          if (accept) begin
            riscv_data    <= stream.s_data;
            riscv_address <= ADDRESS_BITS'(word_cnt);
            if (state == WEIGHTS) wm_enable_write <= NUMBER_OF_UNITS'(1) << unit_cnt;
            else                  bm_enable_write <= NUMBER_OF_UNITS'(1) << unit_cnt;
            // Weight and bias phases share the counters; only the wrap point differs.
            if (word_cnt == last_word) begin
              word_cnt <= '0;
              if (unit_cnt == UNIT_W'(NUMBER_OF_UNITS - 1)) begin
                unit_cnt <= '0;
                if (state == WEIGHTS) begin
                  state <= BIAS;
                end else begin
                  state      <= DONE;
                  load_done  <= 1'b1;
                  conv_ready <= 1'b1;
                end
              end else begin
                unit_cnt <= unit_cnt + 1'b1;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_convb_param_loader.sv
// Bench for convb_param_loader: small-parameter instance checked by table,
// directed sequences and a stream model; default instance checked on a full load.
module tb_convb_param_loader;

  localparam int S_U     = 3;
  localparam int S_W     = 4;
  localparam int S_B     = 2;
  localparam int S_TOTAL = S_U * (S_W + S_B);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic        rst_n, load_start;
  logic [31:0] rdata;
  logic [16:0] raddr;
  logic [2:0]  wm, bm;
  logic        busy, load_done, conv_ready;
  convb_param_loader_if #(.DATA_WIDTH(32)) sif ();

  convb_param_loader #(
    .NUMBER_OF_UNITS (S_U),
    .WEIGHTS_PER_UNIT(S_W),
    .BIAS_PER_UNIT   (S_B)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .load_start     (load_start),
    .stream         (sif),
    .riscv_data     (rdata),
    .riscv_address  (raddr),
    .wm_enable_write(wm),
    .bm_enable_write(bm),
    .busy           (busy),
    .load_done      (load_done),
    .conv_ready     (conv_ready)
  );

  // default-parameter instance
  logic        d_rst_n, d_start;
  logic [31:0] d_rdata;
  logic [16:0] d_raddr;
  logic [10:0] d_wm, d_bm;
  logic        d_busy, d_done, d_conv;
  convb_param_loader_if #(.DATA_WIDTH(32)) dif ();

  convb_param_loader dut_dflt (
    .clk            (clk),
    .reset          (d_rst_n),
    .load_start     (d_start),
    .stream         (dif),
    .riscv_data     (d_rdata),
    .riscv_address  (d_raddr),
    .wm_enable_write(d_wm),
    .bm_enable_write(d_bm),
    .busy           (d_busy),
    .load_done      (d_done),
    .conv_ready     (d_conv)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is a flat sequence of accepts; accept n maps to
  // unit/address by integer division over the weight block then the bias block.
  bit          m_loading = 0, m_done = 0, m_conv = 0;
  int          m_n = 0;
  logic [2:0]  e_wm, e_bm;
  logic [16:0] e_addr;
  logic [31:0] e_data;
  bit          e_wr, e_done;
  int          busy_cnt = 0, strobe_cnt = 0;

  always @(posedge clk) begin
    e_wm = '0; e_bm = '0; e_wr = 0; e_done = 0; e_addr = '0; e_data = '0;
    if (!rst_n) begin
      m_loading = 0; m_done = 0; m_conv = 0; m_n = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_loading) begin
      if (load_start) begin m_loading = 1; m_n = 0; m_conv = 0; end
    end else if (sif.s_valid) begin
      e_wr = 1; e_data = sif.s_data;
      if (m_n < S_U*S_W) begin
        e_wm = 3'(1 << (m_n / S_W)); e_addr = 17'(m_n % S_W);
      end else begin
        e_bm = 3'(1 << ((m_n - S_U*S_W) / S_B)); e_addr = 17'((m_n - S_U*S_W) % S_B);
      end
      m_n++;
      if (m_n == S_TOTAL) begin m_loading = 0; m_done = 1; m_conv = 1; e_done = 1; end
    end
    #1;
    chk("mdl_wm", wm, e_wm);
    chk("mdl_bm", bm, e_bm);
    chk("mdl_load_done", load_done, e_done);
    chk("mdl_conv_ready", conv_ready, m_conv);
    chk("mdl_busy", busy, m_loading);
    chk("mdl_s_ready", sif.s_ready, m_loading);
    if (e_wr) begin
      chk("mdl_addr", raddr, e_addr);
      chk("mdl_data", rdata, e_data);
    end
    if (busy) busy_cnt++;
    if (wm != 0 || bm != 0) strobe_cnt++;
  end

  typedef struct {
    logic [31:0] data;
    logic [2:0]  wm;
    logic [2:0]  bm;
    logic [16:0] addr;
    logic        done;
  } vec_t;
  vec_t vec [S_TOTAL];

  task automatic start_load();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_s_ready", sif.s_ready, 1'b1);
  endtask

  task automatic run_stream(input int max_cycles, input bit toggle, output bit seen);
    seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      sif.s_valid = toggle ? (i % 2 == 0) : 1'b1;
      sif.s_data  = $urandom;
      @(negedge clk);
      if (load_done) seen = 1;
    end
    sif.s_valid = 1'b0;
  endtask

  bit          seen;
  int          acc, done_at;
  logic [16:0] maxa;

  initial begin
    rst_n = 1'b0; load_start = 1'b0; sif.s_valid = 1'b0; sif.s_data = '0;
    d_rst_n = 1'b0; d_start = 1'b0; dif.s_valid = 1'b0; dif.s_data = '0;

    vec[0]  = '{32'd1,  3'b001, 3'b000, 17'd0, 1'b0};
    vec[1]  = '{32'd2,  3'b001, 3'b000, 17'd1, 1'b0};
    vec[2]  = '{32'd3,  3'b001, 3'b000, 17'd2, 1'b0};
    vec[3]  = '{32'd4,  3'b001, 3'b000, 17'd3, 1'b0};
    vec[4]  = '{32'd5,  3'b010, 3'b000, 17'd0, 1'b0};
    vec[5]  = '{32'd6,  3'b010, 3'b000, 17'd1, 1'b0};
    vec[6]  = '{32'd7,  3'b010, 3'b000, 17'd2, 1'b0};
    vec[7]  = '{32'd8,  3'b010, 3'b000, 17'd3, 1'b0};
    vec[8]  = '{32'd9,  3'b100, 3'b000, 17'd0, 1'b0};
    vec[9]  = '{32'd10, 3'b100, 3'b000, 17'd1, 1'b0};
    vec[10] = '{32'd11, 3'b100, 3'b000, 17'd2, 1'b0};
    vec[11] = '{32'd12, 3'b100, 3'b000, 17'd3, 1'b0};
    vec[12] = '{32'd13, 3'b000, 3'b001, 17'd0, 1'b0};
    vec[13] = '{32'd14, 3'b000, 3'b001, 17'd1, 1'b0};
    vec[14] = '{32'd15, 3'b000, 3'b010, 17'd0, 1'b0};
    vec[15] = '{32'd16, 3'b000, 3'b010, 17'd1, 1'b0};
    vec[16] = '{32'd17, 3'b000, 3'b100, 17'd0, 1'b0};
    vec[17] = '{32'd18, 3'b000, 3'b100, 17'd1, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_wm", wm, 3'b000);
    chk("rst_bm", bm, 3'b000);
    chk("rst_addr", raddr, 17'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", sif.s_ready, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_conv_ready", conv_ready, 1'b0);
    chk("rst_dflt_wm", d_wm, 11'h000);
    chk("rst_dflt_conv", d_conv, 1'b0);
    rst_n = 1'b1; d_rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", sif.s_ready, 1'b0);

    // small full load, table driven
    busy_cnt = 0;
    start_load();
    for (int i = 0; i < S_TOTAL; i++) begin
      sif.s_valid = 1'b1; sif.s_data = vec[i].data;
      @(negedge clk);
      chk("tbl_wm", wm, vec[i].wm);
      chk("tbl_bm", bm, vec[i].bm);
      chk("tbl_addr", raddr, vec[i].addr);
      chk("tbl_data", rdata, vec[i].data);
      chk("tbl_load_done", load_done, vec[i].done);
    end
    sif.s_valid = 1'b0;
    @(negedge clk);
    chk("after_load_done", load_done, 1'b0);
    chk("after_conv_ready", conv_ready, 1'b1);
    chk("after_busy", busy, 1'b0);
    chk("busy_cycles", busy_cnt, 18);

    // backpressure
    strobe_cnt = 0;
    start_load();
    run_stream(60, 1'b1, seen);
    chk("bp_done_seen", seen, 1'b1);
    @(negedge clk);
    chk("bp_strobes", strobe_cnt, 18);

    // reset mid-load after 7th accept
    start_load();
    for (int i = 0; i < 7; i++) begin
      sif.s_valid = 1'b1; sif.s_data = $urandom;
      @(negedge clk);
    end
    sif.s_valid = 1'b0;
    chk("mid_wm_before_rst", wm, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wm", wm, 3'b000);
    chk("mid_rst_bm", bm, 3'b000);
    chk("mid_rst_addr", raddr, 17'd0);
    chk("mid_rst_data", rdata, 32'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_s_ready", sif.s_ready, 1'b0);
    chk("mid_rst_conv_ready", conv_ready, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    start_load();
    sif.s_valid = 1'b1; sif.s_data = 32'h0BAD_F00D;
    @(negedge clk);
    sif.s_valid = 1'b0;
    chk("restart_wm", wm, 3'b001);
    chk("restart_addr", raddr, 17'd0);
    chk("restart_data", rdata, 32'h0BAD_F00D);
    run_stream(40, 1'b0, seen);
    chk("restart_done_seen", seen, 1'b1);

    // load_start ignored during WEIGHTS and during DONE
    start_load();
    for (int i = 0; i < 6; i++) begin
      sif.s_valid = 1'b1; sif.s_data = $urandom; load_start = (i == 2);
      @(negedge clk);
    end
    load_start = 1'b0;
    chk("ign_wm", wm, 3'b010);
    chk("ign_addr", raddr, 17'd1);
    run_stream(40, 1'b0, seen);
    chk("ign_done_seen", seen, 1'b1);
    load_start = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", busy, 1'b0);
    @(negedge clk);
    load_start = 1'b0;
    chk("start_from_idle", busy, 1'b1);
    run_stream(40, 1'b0, seen);
    chk("b2b_done_seen", seen, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      load_start  = ($urandom_range(15) == 0);
      sif.s_valid = $urandom_range(1);
      sif.s_data  = $urandom;
      @(negedge clk);
    end
    load_start = 1'b0; sif.s_valid = 1'b0;

    // default parameters, continuous stream
    @(negedge clk) d_start = 1'b1;
    @(negedge clk) d_start = 1'b0;
    chk("dflt_start_busy", d_busy, 1'b1);
    acc = 0; done_at = -1; maxa = '0;
    dif.s_valid = 1'b1;
    for (int i = 0; i < 7000 && done_at < 0; i++) begin
      dif.s_data = $urandom;
      @(negedge clk);
      if (d_wm != 0 || d_bm != 0) begin
        acc++;
        if (d_raddr > maxa) maxa = d_raddr;
        if (acc == 600) begin
          chk("dflt_u0_last_wm", d_wm, 11'h001);
          chk("dflt_u0_last_addr", d_raddr, 17'd599);
        end
        if (acc == 601) begin
          chk("dflt_u1_first_wm", d_wm, 11'h002);
          chk("dflt_u1_first_addr", d_raddr, 17'd0);
        end
        if (acc == 6601) begin
          chk("dflt_bias_first_bm", d_bm, 11'h001);
          chk("dflt_bias_first_addr", d_raddr, 17'd0);
        end
      end
      if (d_done) done_at = acc;
    end
    dif.s_valid = 1'b0;
    chk("dflt_done_count", done_at, 6688);
    chk("dflt_addr_max", maxa, 17'd599);
    chk("dflt_conv_ready", d_conv, 1'b1);
    @(negedge clk);
    chk("dflt_idle_busy", d_busy, 1'b0);
    chk("dflt_done_cleared", d_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
